// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the data memory responder.
// Holds funct3 encodings, bus widths and FSM state encodings.
package data_mem_responder_pkg;

  localparam int ADDR_LEN = 32;
  localparam int DATA_LEN = 32;

  localparam logic [2:0] FUNCT3_B  = 3'b000;
  localparam logic [2:0] FUNCT3_H  = 3'b001;
  localparam logic [2:0] FUNCT3_W  = 3'b010;
  localparam logic [2:0] FUNCT3_BU = 3'b100;
  localparam logic [2:0] FUNCT3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/data_mem_responder_lane_align.sv
// mem_lane_align: funct3/addr lane logic for loads and stores.
// In: funct3, addr_lo, is_store, wdata, rdata. Out: be, wdata_sh, rdata_ext, bad.
module mem_lane_align
  import data_mem_responder_pkg::*;
(
  input  logic [2:0]          funct3,
  input  logic [1:0]          addr_lo,
  input  logic                is_store,
  input  logic [DATA_LEN-1:0] wdata,
  input  logic [DATA_LEN-1:0] rdata,
  output logic [3:0]          be,
  output logic [DATA_LEN-1:0] wdata_sh,
  output logic [DATA_LEN-1:0] rdata_ext,
  output logic                bad
);

  logic [DATA_LEN-1:0] rd_sh;
  logic [7:0]          rd_b;
  logic [15:0]         rd_h;

  // Selected lane is moved down to bit 0 before extension.
  assign rd_sh = rdata >> {addr_lo, 3'b000};
  assign rd_b  = rd_sh[7:0];
  assign rd_h  = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    be        = 4'b0000;
    wdata_sh  = '0;
    rdata_ext = '0;
    bad       = 1'b0;
    unique case (1'b1)
      (funct3 == FUNCT3_B): begin
        be        = 4'b0001 << addr_lo;
        wdata_sh  = {4{wdata[7:0]}};
        rdata_ext = {{24{rd_b[7]}}, rd_b};
      end
      (funct3 == FUNCT3_H): begin
        bad       = addr_lo[0];
        be        = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_sh  = {2{wdata[15:0]}};
        rdata_ext = {{16{rd_h[15]}}, rd_h};
      end
      (funct3 == FUNCT3_W): begin
        bad       = (addr_lo != 2'b00);
        be        = 4'b1111;
        wdata_sh  = wdata;
        rdata_ext = rdata;
      end
      // Unsigned sizes exist only for loads.
      (funct3 == FUNCT3_BU): begin
        bad       = is_store;
        rdata_ext = {24'h0, rd_b};
      end
      (funct3 == FUNCT3_HU): begin
        bad       = is_store | addr_lo[0];
        rdata_ext = {16'h0, rd_h};
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      be        = 4'b0000;
      rdata_ext = '0;
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data RAM responder with wait states, funct3 sizing and response backpressure.
// Ports: req_* valid/ready request channel, resp_* valid/ready response channel.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_wen_i,
  input  logic [2:0]          req_funct3_i,
  input  logic [ADDR_LEN-1:0] req_addr_i,
  input  logic [DATA_LEN-1:0] req_wdata_i,
  output logic                resp_valid_o,
  input  logic                resp_ready_i,
  output logic [DATA_LEN-1:0] resp_rdata_o,
  output logic                resp_err_o
);

  localparam int          IW      = $clog2(DEPTH_WORDS);
  localparam logic [29:0] DEPTH_W = 30'(DEPTH_WORDS);
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  state_t              state;
  logic [3:0]          cnt;
  logic                h_wen;
  logic [2:0]          h_funct3;
  logic [ADDR_LEN-1:0] h_addr;
  logic [DATA_LEN-1:0] h_wdata;

  logic [DATA_LEN-1:0] mem [DEPTH_WORDS];

  // In IDLE the live request drives the datapath so a single-cycle
  // latency can commit on the acceptance edge; otherwise the latched copy.
  logic                cur_wen;
  logic [2:0]          cur_funct3;
  logic [ADDR_LEN-1:0] cur_addr;
  logic [DATA_LEN-1:0] cur_wdata;
  logic [IW-1:0]       idx;
  logic [3:0]          be;
  logic [DATA_LEN-1:0] wdata_sh;
  logic [DATA_LEN-1:0] rdata_ext;
  logic                lane_bad;
  logic                range_bad;
  logic                err;
  logic                accept;
  logic                to_resp;
  logic                commit;
  logic [DATA_LEN-1:0] resp_data;

  assign cur_wen    = (state == IDLE) ? req_wen_i    : h_wen;
  assign cur_funct3 = (state == IDLE) ? req_funct3_i : h_funct3;
  assign cur_addr   = (state == IDLE) ? req_addr_i   : h_addr;
  assign cur_wdata  = (state == IDLE) ? req_wdata_i  : h_wdata;

  assign idx       = cur_addr[IW+1:2];
  assign range_bad = (cur_addr[31:2] >= DEPTH_W);
  assign err       = lane_bad | range_bad;
  assign resp_data = (err | cur_wen) ? '0 : rdata_ext;

  mem_lane_align u_align (
    .funct3    (cur_funct3),
    .addr_lo   (cur_addr[1:0]),
    .is_store  (cur_wen),
    .wdata     (cur_wdata),
    .rdata     (mem[idx]),
    .be        (be),
    .wdata_sh  (wdata_sh),
    .rdata_ext (rdata_ext),
    .bad       (lane_bad)
  );

  assign accept  = req_valid_i & req_ready_o;
  assign to_resp = ((state == WAIT) && (cnt <= 4'd1))
                 | ((state == IDLE) && accept && (LATENCY == 1));
  assign commit  = to_resp & ~rst;

  // Byte-lane write; memory contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (commit && cur_wen && !err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata_sh[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      req_ready_o  <= 1'b1;
      resp_valid_o <= 1'b0;
      resp_rdata_o <= '0;
      resp_err_o   <= 1'b0;
      h_wen        <= 1'b0;
      h_funct3     <= '0;
      h_addr       <= '0;
      h_wdata      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            h_wen       <= req_wen_i;
            h_funct3    <= req_funct3_i;
            h_addr      <= req_addr_i;
            h_wdata     <= req_wdata_i;
            cnt         <= CNT_INIT;
            req_ready_o <= 1'b0;
            if (to_resp) begin
              state        <= RESP;
              resp_valid_o <= 1'b1;
              resp_rdata_o <= resp_data;
              resp_err_o   <= err;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (to_resp) begin
            state        <= RESP;
            resp_valid_o <= 1'b1;
            resp_rdata_o <= resp_data;
            resp_err_o   <= err;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (resp_ready_i) begin
            state        <= IDLE;
            resp_valid_o <= 1'b0;
            req_ready_o  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed scoreboard bench for data_mem_responder.
// Expected responses are queued at drive time and popped on resp_valid_o.
module tb_data_mem_responder;
  import data_mem_responder_pkg::*;

  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_wen_i;
  logic [2:0]  req_funct3_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        resp_valid_o;
  logic        resp_ready_i;
  logic [31:0] resp_rdata_o;
  logic        resp_err_o;

  int n_chk  = 0;
  int n_fail = 0;
  logic [32:0] sb [$];

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_wen_i    (req_wen_i),
    .req_funct3_i (req_funct3_i),
    .req_addr_i   (req_addr_i),
    .req_wdata_i  (req_wdata_i),
    .resp_valid_o (resp_valid_o),
    .resp_ready_i (resp_ready_i),
    .resp_rdata_o (resp_rdata_o),
    .resp_err_o   (resp_err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One request; bp = cycles of response backpressure, ne = expect rdata != exp_rd
  task automatic req(input string tag, input logic wen, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wd,
                     input logic [31:0] exp_rd, input logic exp_err,
                     input int bp, input logic ne);
    int lat;
    logic [32:0] e;
    check({tag, "_ready"}, 32'(req_ready_o), 32'd1);
    resp_ready_i = (bp == 0);
    req_valid_i  = 1'b1;
    req_wen_i    = wen;
    req_funct3_i = f3;
    req_addr_i   = addr;
    req_wdata_i  = wd;
    sb.push_back({exp_err, exp_rd});
    tick();
    // Scramble inputs after acceptance; only latched copies may matter.
    req_valid_i  = 1'b0;
    req_wen_i    = ~wen;
    req_funct3_i = 3'($urandom);
    req_addr_i   = $urandom;
    req_wdata_i  = $urandom;
    lat = 1;
    while (!resp_valid_o && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(LAT));
    e = sb.pop_front();
    if (ne) begin
      n_chk++;
      assert (resp_rdata_o !== e[31:0]) else begin
        n_fail++;
        $error("FAIL %s_rdata_ne observed=%h expected_not=%h",
               tag, resp_rdata_o, e[31:0]);
      end
    end else begin
      check({tag, "_rdata"}, resp_rdata_o, e[31:0]);
    end
    check({tag, "_err"}, 32'(resp_err_o), 32'(e[32]));
    for (int i = 0; i < bp; i++) begin
      tick();
      check({tag, "_bp_valid"}, 32'(resp_valid_o), 32'd1);
      check({tag, "_bp_rdata"}, resp_rdata_o, e[31:0]);
      check({tag, "_bp_ready"}, 32'(req_ready_o), 32'd0);
    end
    resp_ready_i = 1'b1;
    tick();
    check({tag, "_done_valid"}, 32'(resp_valid_o), 32'd0);
    check({tag, "_done_ready"}, 32'(req_ready_o), 32'd1);
  endtask

  initial begin
    rst          = 1'b1;
    req_valid_i  = 1'b0;
    req_wen_i    = 1'b0;
    req_funct3_i = '0;
    req_addr_i   = '0;
    req_wdata_i  = '0;
    resp_ready_i = 1'b1;
    tick();
    tick();
    check("rst_ready", 32'(req_ready_o), 32'd1);
    check("rst_valid", 32'(resp_valid_o), 32'd0);
    check("rst_rdata", resp_rdata_o, 32'd0);
    check("rst_err", 32'(resp_err_o), 32'd0);
    rst = 1'b0;
    tick();

    req("sw10", 1, FUNCT3_W, 32'h10, 32'hDEADBEEF, 32'h0, 0, 0, 0);
    req("lw10a", 0, FUNCT3_W, 32'h10, 32'h0, 32'hDEADBEEF, 0, 0, 0);
    req("sb11", 1, FUNCT3_B, 32'h11, 32'h000000AA, 32'h0, 0, 0, 0);
    req("lb11", 0, FUNCT3_B, 32'h11, 32'h0, 32'hFFFFFFAA, 0, 0, 0);
    req("lbu11", 0, FUNCT3_BU, 32'h11, 32'h0, 32'h000000AA, 0, 0, 0);
    req("lw10b", 0, FUNCT3_W, 32'h10, 32'h0, 32'hDEADAAEF, 0, 0, 0);
    req("sh12", 1, FUNCT3_H, 32'h12, 32'h00008001, 32'h0, 0, 0, 0);
    req("lh12", 0, FUNCT3_H, 32'h12, 32'h0, 32'hFFFF8001, 0, 0, 0);
    req("lhu12", 0, FUNCT3_HU, 32'h12, 32'h0, 32'h00008001, 0, 0, 0);
    req("lw10c", 0, FUNCT3_W, 32'h10, 32'h0, 32'h8001AAEF, 0, 0, 0);
    req("lb13", 0, FUNCT3_B, 32'h13, 32'h0, 32'hFFFFFF80, 0, 0, 0);
    req("lh10", 0, FUNCT3_H, 32'h10, 32'h0, 32'hFFFFAAEF, 0, 0, 0);

    req("lw13_err", 0, FUNCT3_W, 32'h13, 32'h0, 32'h0, 1, 0, 0);
    req("sh11_err", 1, FUNCT3_H, 32'h11, 32'h0000FFFF, 32'h0, 1, 0, 0);
    req("lw10d", 0, FUNCT3_W, 32'h10, 32'h0, 32'h8001AAEF, 0, 0, 0);
    req("f011_err", 0, 3'b011, 32'h10, 32'h0, 32'h0, 1, 0, 0);
    req("sbu_err", 1, FUNCT3_BU, 32'h10, 32'h55, 32'h0, 1, 0, 0);
    req("oor_err", 0, FUNCT3_W, 32'(4 * DEPTH), 32'h0, 32'h0, 1, 0, 0);
    req("oor_sw", 1, FUNCT3_W, 32'(4 * DEPTH) + 32'h10, 32'h11111111,
        32'h0, 1, 0, 0);
    req("lw10e", 0, FUNCT3_W, 32'h10, 32'h0, 32'h8001AAEF, 0, 0, 0);
    req("top_sw", 1, FUNCT3_W, 32'(4 * DEPTH - 4), 32'hCAFEF00D,
        32'h0, 0, 0, 0);
    req("top_lw", 0, FUNCT3_W, 32'(4 * DEPTH - 4), 32'h0, 32'hCAFEF00D,
        0, 0, 0);

    req("bp_lw", 0, FUNCT3_W, 32'h10, 32'h0, 32'h8001AAEF, 0, 5, 0);

    // Reset while waiting aborts the store and yields no response.
    check("abort_ready0", 32'(req_ready_o), 32'd1);
    req_valid_i  = 1'b1;
    req_wen_i    = 1'b1;
    req_funct3_i = FUNCT3_W;
    req_addr_i   = 32'h20;
    req_wdata_i  = 32'h12345678;
    tick();
    req_valid_i = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_ready", 32'(req_ready_o), 32'd1);
    check("abort_valid", 32'(resp_valid_o), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("abort_novalid", 32'(resp_valid_o), 32'd0);
    end
    req("abort_lw", 0, FUNCT3_W, 32'h20, 32'h0, 32'h12345678, 0, 0, 1);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
